sgpr_busy_table_mp: RTL and testbench
=====================================

Name: sgpr_busy_table_mp

Overview:
- Multi-port scalar-register scoreboard for the issue stage.
- Holds one busy bit per SGPR. Issue marks a destination run of 1..MAX_WORDS registers busy, and writeback clears a run.
- Each of NUM_RD_PORTS query ports returns a registered MAX_WORDS-bit busy window starting at any SGPR address. The window wraps modulo NUM_ENTRIES.
- Generalises the single combinational window mux to a stateful, multi-port, width-parametrised table with occupancy tracking.

Parameters:
- NUM_ENTRIES, 104: number of SGPRs tracked.
- ADDR_W, 9: SGPR address width.
- MAX_WORDS, 4: maximum run length for set, clear and query windows; must be ≤ NUM_ENTRIES.
- SIZE_W, 2: width of size fields; encoded run length = size+1; must satisfy 2^SIZE_W ≤ MAX_WORDS.
- NUM_RD_PORTS, 2: number of independent query ports.
- CNT_W, 7: width of busy_count; must hold NUM_ENTRIES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- set_en  in  1  mark run busy (issue of SGPR writer)
- set_addr  in  ADDR_W  first SGPR of run
- set_size  in  SIZE_W  run length minus one
- clr_en  in  1  mark run free (SGPR writeback)
- clr_addr  in  ADDR_W  first SGPR of run
- clr_size  in  SIZE_W  run length minus one
- rd_req  in  NUM_RD_PORTS  per-port query strobe
- rd_addr  in  NUM_RD_PORTS*ADDR_W  per-port window base; port p occupies bits [p*ADDR_W +: ADDR_W]
- rd_valid  out  NUM_RD_PORTS  per-port result valid
- rd_busy  out  NUM_RD_PORTS*MAX_WORDS  per-port window; bit k = busy[(addr+k) mod NUM_ENTRIES]
- busy_count  out  CNT_W  number of busy entries
- all_idle  out  1  busy_count == 0
- err_oob  out  1  sticky out-of-range address error

Behaviour:
- Reset (async, rst=1): busy table all 0, rd_valid=0, rd_busy=0, busy_count=0, all_idle=1, err_oob=0. Reset asserted mid-operation discards any in-flight query result.
- Run expansion: entry index i = (addr+k) mod NUM_ENTRIES for k=0..size. Wrap-around is explicit: addr=NUM_ENTRIES-1 with size=1 covers entries NUM_ENTRIES-1 and 0.
- Update occurs on the clk rising edge:
  - next_busy = (busy & ~clr_mask) | set_mask.
  - If set and clear hit the same entry in the same cycle, set wins (the new producer follows the retiring one).
  - Setting an already-busy bit or clearing an idle bit is legal and has no side effect beyond the bit value.
- Query latency is 1 cycle:
  - rd_req[p] at edge N gives rd_valid[p]=1 and rd_busy[p] sampled from the busy state before edge N's update.
  - rd_valid[p]=0 in any cycle following no request; rd_busy[p] holds its last value.
  - Ports are fully independent; identical addresses on several ports are legal.
- busy_count is registered and equals the popcount of the busy table after each edge. It updates in the same edge as the table and never exceeds NUM_ENTRIES. all_idle is derived from the registered count.
- Out-of-range (addr ≥ NUM_ENTRIES):
  - Set/clear: the request is dropped entirely and err_oob sets.
  - Query: rd_busy returns all ones (conservative stall), rd_valid=1, and err_oob sets.
  - err_oob clears only on reset.
- Sizes: size+1 > MAX_WORDS cannot be encoded given the parameter constraint; no checking is required.

Optional Feature:
- Macro: SGPR_BUSY_BYPASS_EN.
- With the macro defined: a query result additionally reflects same-edge updates, i.e. rd_busy is sampled from next_busy. A clear and a query in the same cycle return 0 for cleared bits; a set and a query in the same cycle return 1. This saves one stall cycle on writeback-to-issue.
- Without the macro: queries see the pre-update state as specified above.
- busy_count timing is identical in both builds.

Test Plan:
- Reset, then query port0 addr 0 → next cycle rd_valid=01, rd_busy[port0]=4'b0000, busy_count=0, all_idle=1.
- set addr 10 size 3, next cycle query addr 9 → rd_busy=4'b1110, busy_count=4; clr addr 11 size 1 → busy_count=2, query addr 9 → 4'b0010.
- Wrap: set addr 103 size 1, query addr 102 → 4'b0110 (entries 103, 0 busy), busy_count=2.
- Same-cycle set addr 20 size 0 and clr addr 20 size 0 on an idle entry → entry 20 busy, busy_count=1. With both ports querying addr 20 in that cycle:
  - Without bypass: both return 4'b0000.
  - With SGPR_BUSY_BYPASS_EN: both return 4'b0001.
- set addr 110 → table unchanged, err_oob=1. Query addr 120 → rd_busy=4'b1111. err_oob stays 1 until rst.
- Set 5 entries, assert rst asynchronously mid-cycle while rd_req is high → outputs zero immediately, no rd_valid pulse after release, all_idle=1.

Source files
------------

// File: rtl/sgpr_busy_table_mp.sv
// Multi-port SGPR busy scoreboard: run set/clear, 1-cycle registered query windows, no backpressure.
// Define SGPR_BUSY_BYPASS_EN to make queries see same-edge set/clear updates.
module sgpr_busy_table_mp #(
  parameter int NUM_ENTRIES  = 104,
  parameter int ADDR_W       = 9,
  parameter int MAX_WORDS    = 4,
  parameter int SIZE_W       = 2,
  parameter int NUM_RD_PORTS = 2,
  parameter int CNT_W        = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             set_en,
  input  logic [ADDR_W-1:0]                set_addr,
  input  logic [SIZE_W-1:0]                set_size,
  input  logic                             clr_en,
  input  logic [ADDR_W-1:0]                clr_addr,
  input  logic [SIZE_W-1:0]                clr_size,
  input  logic [NUM_RD_PORTS-1:0]          rd_req,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD_PORTS-1:0]          rd_valid,
  output logic [NUM_RD_PORTS*MAX_WORDS-1:0] rd_busy,
  output logic [CNT_W-1:0]                 busy_count,
  output logic                             all_idle,
  output logic                             err_oob
);

  localparam int AW1 = ADDR_W + 1;

  logic [NUM_ENTRIES-1:0]            busy_q, busy_d;
  logic [NUM_ENTRIES-1:0]            set_mask, clr_mask, rd_src;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_RD_PORTS-1:0]           rd_valid_q;
  logic [NUM_RD_PORTS*MAX_WORDS-1:0] rd_busy_q, rd_busy_d;
  logic [NUM_RD_PORTS-1:0]           rd_oob;
  logic                              err_q, err_d;
  logic                              set_oob, clr_oob;

  // Index of base+k modulo NUM_ENTRIES; base is assumed in range here.
  function automatic logic [AW1-1:0] wrap_sum(input logic [ADDR_W-1:0] base, input int k);
    logic [AW1-1:0] sum;
    sum = {1'b0, base} + AW1'(k);
    if (sum >= AW1'(NUM_ENTRIES)) sum = sum - AW1'(NUM_ENTRIES);
    return sum;
  endfunction

  function automatic logic [NUM_ENTRIES-1:0] run_mask(input logic [ADDR_W-1:0] base,
                                                      input logic [SIZE_W-1:0] size);
    logic [AW1-1:0] idx;
    run_mask = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      idx = wrap_sum(base, k);
      if (k <= int'(size)) begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
          if (idx == AW1'(e)) run_mask[e] = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [MAX_WORDS-1:0] window(input logic [NUM_ENTRIES-1:0] src,
                                                  input logic [ADDR_W-1:0] base);
    logic [AW1-1:0] idx;
    window = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      idx = wrap_sum(base, k);
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (idx == AW1'(e)) window[k] = src[e];
      end
    end
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ENTRIES-1:0] v);
    popcount = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) popcount = popcount + CNT_W'(v[e]);
  endfunction

  // Out-of-range runs are dropped whole rather than partially wrapped.
  always_comb begin
    set_oob  = set_addr >= ADDR_W'(NUM_ENTRIES);
    clr_oob  = clr_addr >= ADDR_W'(NUM_ENTRIES);
    set_mask = (set_en && !set_oob) ? run_mask(set_addr, set_size) : '0;
    clr_mask = (clr_en && !clr_oob) ? run_mask(clr_addr, clr_size) : '0;
    busy_d   = (busy_q & ~clr_mask) | set_mask;
    cnt_d    = popcount(busy_d);
  end

`ifdef SGPR_BUSY_BYPASS_EN
  assign rd_src = busy_d;
`else
  assign rd_src = busy_q;
`endif

  // Out-of-range queries report all-busy so the issuer stalls conservatively.
  always_comb begin
    rd_busy_d = rd_busy_q;
    rd_oob    = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_oob[p] = rd_addr[p*ADDR_W +: ADDR_W] >= ADDR_W'(NUM_ENTRIES);
      if (rd_req[p]) begin
        rd_busy_d[p*MAX_WORDS +: MAX_WORDS] =
          rd_oob[p] ? '1 : window(rd_src, rd_addr[p*ADDR_W +: ADDR_W]);
      end
    end
    err_d = err_q | (set_en & set_oob) | (clr_en & clr_oob) | (|(rd_req & rd_oob));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= '0;
      rd_busy_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_req;
      rd_busy_q  <= rd_busy_d;
      err_q      <= err_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_busy    = rd_busy_q;
  assign busy_count = cnt_q;
  assign all_idle   = (cnt_q == '0);
  assign err_oob    = err_q;

endmodule

// File: tb/tb_sgpr_busy_table_mp.sv
// Directed vector bench for sgpr_busy_table_mp (expectations adapt to SGPR_BUSY_BYPASS_EN).
module tb_sgpr_busy_table_mp;

`ifdef SGPR_BUSY_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_en = 1'b0, clr_en = 1'b0;
  logic [8:0] set_addr = '0, clr_addr = '0;
  logic [1:0] set_size = '0, clr_size = '0;
  logic [1:0] rd_req = '0;
  logic [17:0] rd_addr = '0;
  logic [1:0] rd_valid;
  logic [7:0] rd_busy;
  logic [6:0] busy_count;
  logic       all_idle;
  logic       err_oob;

  int n_cmp = 0;
  int n_bad = 0;

  sgpr_busy_table_mp dut (
    .clk(clk), .rst(rst),
    .set_en(set_en), .set_addr(set_addr), .set_size(set_size),
    .clr_en(clr_en), .clr_addr(clr_addr), .clr_size(clr_size),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_busy(rd_busy),
    .busy_count(busy_count), .all_idle(all_idle), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s_en;  logic [8:0] s_a; logic [1:0] s_sz;
    logic       c_en;  logic [8:0] c_a; logic [1:0] c_sz;
    logic [1:0] req;   logic [8:0] a0;  logic [8:0] a1;
    logic [1:0] e_vld; logic [3:0] e_b0; logic [3:0] e_b1;
    logic [6:0] e_cnt; logic e_err;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic s_en, int s_a, int s_sz, logic c_en, int c_a, int c_sz,
                              logic [1:0] req, int a0, int a1,
                              logic [1:0] e_vld, logic [3:0] e_b0, logic [3:0] e_b1,
                              int e_cnt, logic e_err);
    vec_t v;
    v.s_en = s_en; v.s_a = 9'(s_a); v.s_sz = 2'(s_sz);
    v.c_en = c_en; v.c_a = 9'(c_a); v.c_sz = 2'(c_sz);
    v.req = req; v.a0 = 9'(a0); v.a1 = 9'(a1);
    v.e_vld = e_vld; v.e_b0 = e_b0; v.e_b1 = e_b1;
    v.e_cnt = 7'(e_cnt); v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    set_en = 1'b0; clr_en = 1'b0; rd_req = '0;
  endtask

  initial begin
    // Expected values assume the table state built up by the preceding rows.
    vecs[0]  = mk(0,   0,0, 0,  0,0, 2'b01,   0,  0, 2'b01, 4'b0000, 4'b0000, 0, 0);
    vecs[1]  = mk(1,  10,3, 0,  0,0, 2'b00,   0,  0, 2'b00, 4'b0000, 4'b0000, 4, 0);
    vecs[2]  = mk(0,   0,0, 0,  0,0, 2'b11,   9, 12, 2'b11, 4'b1110, 4'b0011, 4, 0);
    vecs[3]  = mk(0,   0,0, 1, 11,1, 2'b01,   9,  0, 2'b01,
                  BYP ? 4'b0010 : 4'b1110, 4'b0011, 2, 0);
    vecs[4]  = mk(0,   0,0, 0,  0,0, 2'b11,   9, 10, 2'b11, 4'b0010, 4'b1001, 2, 0);
    vecs[5]  = mk(1, 103,1, 0,  0,0, 2'b00,   0,  0, 2'b00, 4'b0010, 4'b1001, 4, 0);
    vecs[6]  = mk(0,   0,0, 0,  0,0, 2'b11, 102,101, 2'b11, 4'b0110, 4'b1100, 4, 0);
    vecs[7]  = mk(0,   0,0, 1, 13,3, 2'b10,   0, 13, 2'b10, 4'b0110,
                  BYP ? 4'b0000 : 4'b0001, 3, 0);
    vecs[8]  = mk(1,  20,0, 1, 20,0, 2'b11,  20, 20, 2'b11,
                  BYP ? 4'b0001 : 4'b0000, BYP ? 4'b0001 : 4'b0000, 4, 0);
    vecs[9]  = mk(0,   0,0, 0,  0,0, 2'b11,  20, 20, 2'b11, 4'b0001, 4'b0001, 4, 0);
    vecs[10] = mk(1, 110,0, 0,  0,0, 2'b00,   0,  0, 2'b00, 4'b0001, 4'b0001, 4, 1);
    vecs[11] = mk(0,   0,0, 0,  0,0, 2'b11, 120,103, 2'b11, 4'b1111, 4'b0011, 4, 1);
    vecs[12] = mk(0,   0,0, 1,100,3, 2'b00,   0,  0, 2'b00, 4'b1111, 4'b0011, 3, 1);
    vecs[13] = mk(1,  50,2, 1,  0,0, 2'b11,  49,  0, 2'b11,
                  BYP ? 4'b1110 : 4'b0000, BYP ? 4'b0000 : 4'b0001, 5, 1);
    vecs[14] = mk(0,   0,0, 1,104,0, 2'b10,   0,104, 2'b10,
                  BYP ? 4'b1110 : 4'b0000, 4'b1111, 5, 1);

    #12;
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset rd_busy", 32'(rd_busy), 0);
    chk("reset busy_count", 32'(busy_count), 0);
    chk("reset all_idle", 32'(all_idle), 1);
    chk("reset err_oob", 32'(err_oob), 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      set_en = vecs[i].s_en; set_addr = vecs[i].s_a; set_size = vecs[i].s_sz;
      clr_en = vecs[i].c_en; clr_addr = vecs[i].c_a; clr_size = vecs[i].c_sz;
      rd_req = vecs[i].req;
      rd_addr = {vecs[i].a1, vecs[i].a0};
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d rd_busy0", i), 32'(rd_busy[3:0]), 32'(vecs[i].e_b0));
      chk($sformatf("v%0d rd_busy1", i), 32'(rd_busy[7:4]), 32'(vecs[i].e_b1));
      chk($sformatf("v%0d busy_count", i), 32'(busy_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d all_idle", i), 32'(all_idle), 32'(vecs[i].e_cnt == 0));
      chk($sformatf("v%0d err_oob", i), 32'(err_oob), 32'(vecs[i].e_err));
    end

    // Asynchronous reset in the middle of a cycle with queries outstanding.
    @(negedge clk);
    drive_idle();
    rd_req = 2'b11;
    rd_addr = {9'd50, 9'd50};
    #2 rst = 1'b1;
    #1;
    chk("arst rd_valid", 32'(rd_valid), 0);
    chk("arst rd_busy", 32'(rd_busy), 0);
    chk("arst busy_count", 32'(busy_count), 0);
    chk("arst all_idle", 32'(all_idle), 1);
    chk("arst err_oob", 32'(err_oob), 0);
    @(posedge clk);
    #1;
    rd_req = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst rd_valid", 32'(rd_valid), 0);
    chk("post-rst busy_count", 32'(busy_count), 0);
    chk("post-rst all_idle", 32'(all_idle), 1);

    // The table itself must be cleared, not just the outputs.
    @(negedge clk);
    rd_req = 2'b01;
    rd_addr = {9'd0, 9'd50};
    @(posedge clk);
    #1;
    chk("post-rst query valid", 32'(rd_valid), 32'(2'b01));
    chk("post-rst query busy0", 32'(rd_busy[3:0]), 0);
    @(negedge clk);
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
